// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU encodings,
// FSM state type and the bundled control-strobe record.
package multicycle_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       ir_load;
    logic       pc_ld;
    logic       branch;
    logic       flush;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       wb_sel;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode: {state, latched opcode, zero} -> control strobes.
import multicycle_pkg::*;

module ctrl_decode (
  input  state_e     state,
  input  logic [3:0] op,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Per-state strobe generation; everything defaults low.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_load = 1'b1;
        ctrl.pc_ld   = 1'b1;
      end
      S_EXECUTE: begin
        case (op)
          OP_ADD:            ctrl.alu_op = ALU_ADD;
          OP_SUB:            ctrl.alu_op = ALU_SUB;
          OP_AND:            ctrl.alu_op = ALU_AND;
          OP_OR:             ctrl.alu_op = ALU_OR;
          OP_LOAD, OP_STORE: ctrl.alu_op = ALU_ADD;
          OP_JMP: begin
            ctrl.branch = 1'b1;
            ctrl.flush  = 1'b1;
          end
          OP_BEQ: begin
            ctrl.branch = zero;
            ctrl.flush  = zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_read  = (op == OP_LOAD);
        ctrl.mem_write = (op == OP_STORE);
      end
      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (op == OP_LOAD);
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing fetch and execute, one instruction at a time.
// Optional CTRL_STALL_EN: adds mem_ready and holds MEM until it is high.
import multicycle_pkg::*;

module multicycle_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
`ifdef CTRL_STALL_EN
  input  logic               mem_ready,
`endif
  output logic               ir_load,
  output logic               pc_ld,
  output logic               branch,
  output logic [ADDR_W-1:0]  branch_addr,
  output logic               flush,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_sel,
  output logic               halted
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] branch_addr_q, branch_addr_d;
  logic [3:0]        opcode;
  logic              mem_done;
  logic              unused_instr_bits;
  ctrl_t             dec;
  ctrl_t             ctrl;

  assign opcode            = instr[INSTR_W-1 -: 4];
  assign unused_instr_bits = ^instr[INSTR_W-5:8];

`ifdef CTRL_STALL_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // Next-state logic and DECODE-time capture of opcode / branch target.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    branch_addr_d = branch_addr_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d          = opcode;
        branch_addr_d = ADDR_W'(instr[7:0]);
        state_d       = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_WB;
          OP_LOAD, OP_STORE:             state_d = S_MEM;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_done) state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State and latched-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      branch_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      branch_addr_q <= branch_addr_d;
    end
  end

  ctrl_decode u_decode (
    .state (state_q),
    .op    (op_q),
    .zero  (zero),
    .ctrl  (dec)
  );

  // Reset state is FETCH, so strobes are masked by rst to keep them low while
  // reset is held and to kill any strobe the instant reset asserts.
  assign ctrl        = rst ? '0 : dec;
  assign ir_load     = ctrl.ir_load;
  assign pc_ld       = ctrl.pc_ld;
  assign branch      = ctrl.branch;
  assign flush       = ctrl.flush;
  assign alu_op      = ctrl.alu_op;
  assign reg_write   = ctrl.reg_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign wb_sel      = ctrl.wb_sel;
  assign halted      = ctrl.halted;
  assign branch_addr = branch_addr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions
// checked cycle by cycle against a per-instruction timeline model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        zero = 1'b0;
`ifdef CTRL_STALL_EN
  logic        mem_ready = 1'b1;
`endif
  logic        ir_load, pc_ld, branch, flush, reg_write, mem_read, mem_write, wb_sel, halted;
  logic [1:0]  alu_op;
  logic [7:0]  branch_addr;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [7:0]  ba_exp      = '0;
  logic [10:0] exp_q[$];

  // {ir_load, pc_ld, branch, flush, alu_op[1:0], reg_write, mem_read, mem_write, wb_sel, halted}
  localparam logic [10:0] V_IDLE  = 11'b000_0000_0000;
  localparam logic [10:0] V_FETCH = 11'b110_0000_0000;
  localparam logic [10:0] V_BRF   = 11'b001_1000_0000;
  localparam logic [10:0] V_RW    = 11'b000_0001_0000;
  localparam logic [10:0] V_RWL   = 11'b000_0001_0010;
  localparam logic [10:0] V_MR    = 11'b000_0000_1000;
  localparam logic [10:0] V_MW    = 11'b000_0000_0100;
  localparam logic [10:0] V_HALT  = 11'b000_0000_0001;

  wire [10:0] obs_vec = {ir_load, pc_ld, branch, flush, alu_op,
                         reg_write, mem_read, mem_write, wb_sel, halted};

  multicycle_ctrl #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .zero        (zero),
`ifdef CTRL_STALL_EN
    .mem_ready   (mem_ready),
`endif
    .ir_load     (ir_load),
    .pc_ld       (pc_ld),
    .branch      (branch),
    .branch_addr (branch_addr),
    .flush       (flush),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .wb_sel      (wb_sel),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected per-cycle output timeline of one instruction, from the ISA description.
  function automatic void build(input logic [15:0] ins, input logic [15:0] zv,
                                input int unsigned stall);
    logic [3:0] op;
    logic [3:0] alu;
    op  = ins[15:12];
    alu = op - 4'h1;
    exp_q.delete();
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_IDLE);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        exp_q.push_back({4'b0000, alu[1:0], 5'b00000});
        exp_q.push_back(V_RW);
      end
      4'h5: begin
        exp_q.push_back(V_IDLE);
        for (int unsigned i = 0; i <= stall; i++) exp_q.push_back(V_MR);
        exp_q.push_back(V_RWL);
      end
      4'h6: begin
        exp_q.push_back(V_IDLE);
        for (int unsigned i = 0; i <= stall; i++) exp_q.push_back(V_MW);
      end
      4'h7:    exp_q.push_back(zv[2] ? V_BRF : V_IDLE);
      4'h8:    exp_q.push_back(V_BRF);
      4'hF:    for (int unsigned i = 0; i < 5; i++) exp_q.push_back(V_HALT);
      default: exp_q.push_back(V_IDLE);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; abort_at >= 0 asserts rst in that cycle.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] zv,
                           input int unsigned stall, input int abort_at);
    int unsigned n;
    build(ins, zv, stall);
    n     = exp_q.size();
    instr = ins;
    zero  = zv[0];
`ifdef CTRL_STALL_EN
    mem_ready = (stall == 0) ? 1'b0 : 1'b0;
`endif
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("op%h_c%0d_ctl", ins[15:12], k), {5'b0, obs_vec}, {5'b0, exp_q[k]});
      chk($sformatf("op%h_c%0d_baddr", ins[15:12], k), {8'b0, branch_addr},
          {8'b0, (k >= 2) ? ins[7:0] : ba_exp});
      if (abort_at == int'(k)) begin
        rst = 1'b1;
        #1;
        chk("abort_ctl", {5'b0, obs_vec}, 16'h0000);
        chk("abort_baddr", {8'b0, branch_addr}, 16'h0000);
        ba_exp = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (k + 1 < n) begin
        instr = (k + 1 <= 1) ? ins : 16'($urandom);
        zero  = zv[k+1];
`ifdef CTRL_STALL_EN
        mem_ready = (k + 1 >= 3 + stall);
`endif
      end
    end
    ba_exp = ins[7:0];
  endtask

  initial begin
    logic [3:0]  rop;
    int unsigned st;

    // Reset held: all outputs low, branch_addr cleared.
    repeat (3) @(negedge clk);
    chk("reset_ctl", {5'b0, obs_vec}, 16'h0000);
    chk("reset_baddr", {8'b0, branch_addr}, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(16'h1000, 16'h0000, 0, -1);   // ADD
    run_instr(16'h5000, 16'h0000, 0, -1);   // LOAD
`ifdef CTRL_STALL_EN
    run_instr(16'h5000, 16'h0000, 3, -1);   // LOAD, mem_ready low 3 cycles
    run_instr(16'h6011, 16'h0000, 2, -1);   // STORE, stalled
`endif
    run_instr(16'h7042, 16'hFFFF, 0, -1);   // BEQ taken
    run_instr(16'h7042, 16'hFFFB, 0, -1);   // BEQ not taken; zero high outside EXECUTE
    run_instr(16'h8013, 16'h0000, 0, -1);   // JMP
    run_instr(16'hB000, 16'hFFFF, 0, -1);   // undefined opcode -> NOP
    run_instr(16'h6077, 16'h0000, 0, -1);   // STORE
    run_instr(16'h4000, 16'h0000, 0, -1);   // OR
    run_instr(16'h1000, 16'h0000, 0, 3);    // ADD aborted by rst in WB
    run_instr(16'h3055, 16'h0000, 0, -1);   // AND after abort

    for (int unsigned i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 14));
`ifdef CTRL_STALL_EN
      st = $urandom_range(0, 3);
`else
      st = 0;
`endif
      run_instr({rop, 12'($urandom)}, 16'($urandom), st, -1);
    end

    run_instr(16'hF0A5, 16'h0000, 0, -1);   // HALT: stays halted, no ir_load
    rst = 1'b1;
    #1;
    chk("halt_reset_ctl", {5'b0, obs_vec}, 16'h0000);
    ba_exp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(16'h2099, 16'h0000, 0, -1);   // SUB after leaving HALT

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sequences the instruction fetch unit (program counter, instruction memory, instruction register) and the execute datapath. It issues IR load, PC advance, branch, and flush strobes to the fetch unit. It decodes the 16-bit instruction held in the IR and drives ALU, register-file and data-memory controls, one instruction at a time. It sits between the fetch unit and the register file / ALU / data memory.

## Interface
Parameters:
- ADDR_W, 8, PC / branch target width
- INSTR_W, 16, instruction width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  INSTR_W  current IR contents
- zero  in  1  registered ALU zero flag from the datapath
- ir_load  out  1  IR capture strobe
- pc_ld  out  1  PC increment strobe
- branch  out  1  PC load-from-branch_addr strobe
- branch_addr  out  ADDR_W  branch target, equal to instr[7:0] latched at DECODE
- flush  out  1  IR clear strobe
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- reg_write  out  1  register-file write enable
- mem_read  out  1  data-memory read enable
- mem_write  out  1  data-memory write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  core stopped
- mem_ready  in  1  data-memory ready; present only with CTRL_STALL_EN

## Operation
- Opcode is instr[15:12]. Encodings: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LOAD, 6 STORE, 7 BEQ, 8 JMP, F HALT. All other opcodes execute as NOP.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: ir_load=1 and pc_ld=1 for exactly one cycle. Next state is DECODE.
- DECODE: latch opcode into op_q and instr[7:0] into branch_addr. Next state is HALT when the opcode is F, otherwise EXECUTE.
- EXECUTE:
  - ALU ops drive alu_op and go to WB.
  - LOAD and STORE drive alu_op=00 (address add) and go to MEM.
  - JMP, or BEQ with zero=1: branch=1 and flush=1 for one cycle, then FETCH.
  - BEQ with zero=0, and NOP: go to FETCH with no strobes.
- MEM:
  - LOAD: mem_read=1, then WB.
  - STORE: mem_write=1, then FETCH.
- WB: reg_write=1. wb_sel=1 for LOAD, 0 otherwise. Next state is FETCH.
- HALT: halted=1, all strobes 0. The FSM remains in HALT until rst.
- All outputs are decoded from state and op_q. Only one of ir_load, branch, mem_read, mem_write, reg_write is active in any cycle.

## Timing
- Reset: state=FETCH, op_q=0, branch_addr=0, all outputs 0. The first ir_load is in the first cycle after rst deasserts.
- Assertion of rst mid-instruction aborts it immediately. Any strobe active in that cycle deasserts asynchronously. No partial write-back occurs.
- Cycles per instruction:
  - NOP, BEQ, JMP: 3
  - ADD, SUB, AND, OR, STORE: 4
  - LOAD: 5
  - HALT: reaches the HALT state 2 cycles after FETCH
- A branch taken in EXECUTE updates PC at that edge. The following FETCH reads the target, so there is no extra bubble.
- zero is sampled only in the EXECUTE cycle of a BEQ.

## Configuration
- CTRL_STALL_EN defined: the mem_ready port exists.
  - MEM holds mem_read or mem_write asserted and stays in MEM until mem_ready=1.
  - mem_ready=1 in the first MEM cycle gives the same latency as the build without the macro.
- CTRL_STALL_EN undefined: there is no mem_ready port and MEM always lasts exactly one cycle.

## Structure
- Shared package multicycle_pkg: opcode localparams, the state enum typedef, and the alu_op encodings.
- One sub-module, ctrl_decode: combinational mapping from {state, op_q, zero} to the output strobes. The FSM register and next-state logic stay in multicycle_ctrl.

## Test plan
- Reset then instr=0x1000 (ADD): ir_load in cycle 1, alu_op=00 in cycle 3, reg_write=1 wb_sel=0 in cycle 4, ir_load again in cycle 5.
- instr=0x5000 (LOAD): mem_read=1 in cycle 4, then reg_write=1 wb_sel=1 in cycle 5. With CTRL_STALL_EN and mem_ready low for 3 cycles, mem_read is held 4 cycles.
- instr=0x7042 (BEQ) with zero=1: branch=1, flush=1, branch_addr=0x42 in cycle 3. With zero=0: no branch, FETCH in cycle 4.
- instr=0x8013 (JMP): branch=1, branch_addr=0x13 in cycle 3. Next FETCH in cycle 4.
- instr=0xF000 (HALT): halted=1 from cycle 3 onward with no further ir_load. instr=0xB000 behaves as a 3-cycle NOP.
- rst asserted during the WB cycle: reg_write drops immediately and all outputs read 0. ir_load is the first strobe after release.
